// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - halfword prefetch queue realigning L1I words into RV32IC instructions
// Words enter as one or two halfwords; the head presents a 16- or 32-bit instruction with its PC.
module fetch_buffer #(
  parameter int unsigned     DEPTH_HALVES = 8,
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC     = '0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [XLEN-1:0]               flush_pc,
  output logic                          fetch_req,
  output logic [XLEN-1:0]               fetch_addr,
  input  logic                          fetch_valid,
  input  logic [31:0]                   fetch_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   out_instruction,
  output logic [XLEN-1:0]               out_pc,
  output logic                          out_is_compact,
  output logic [$clog2(DEPTH_HALVES):0] count
);

  localparam int unsigned     PW      = $clog2(DEPTH_HALVES);
  localparam int unsigned     CW      = PW + 1;
  localparam logic [XLEN-1:0] PC_MASK = {{(XLEN-1){1'b1}}, 1'b0};

  logic [15:0]     mem_q [DEPTH_HALVES];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] head_pc_q, head_pc_d;

  logic [15:0]     h0, h1;
  logic            compact;
  logic            push, pop;
  logic [CW-1:0]   push_n, pop_n;

  always_comb begin
    h0      = mem_q[rd_ptr_q];
    h1      = mem_q[rd_ptr_q + PW'(1)];
    compact = (h0[1:0] != 2'b11);
    // Free space is judged from the registered count only, so out_ready never reaches fetch_req.
    fetch_req  = !flush && (count_q <= CW'(DEPTH_HALVES - 2));
    fetch_addr = {fetch_pc_q[XLEN-1:2], 2'b00};
    out_valid  = ((count_q >= CW'(1)) && compact) || (count_q >= CW'(2));
    out_instruction = compact ? {16'h0000, h0} : {h1, h0};
    out_is_compact  = compact;
    out_pc          = head_pc_q;
    count           = count_q;

    push   = fetch_req && fetch_valid;
    pop    = out_valid && out_ready && !flush;
    push_n = fetch_pc_q[1] ? CW'(1) : CW'(2);
    pop_n  = compact ? CW'(1) : CW'(2);

    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    fetch_pc_d = fetch_pc_q;
    head_pc_d  = head_pc_q;

    if (flush) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = flush_pc & PC_MASK;
      head_pc_d  = flush_pc & PC_MASK;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + push_n[PW-1:0];
        fetch_pc_d = fetch_pc_q + (fetch_pc_q[1] ? XLEN'(2) : XLEN'(4));
      end
      if (pop) begin
        rd_ptr_d  = rd_ptr_q + pop_n[PW-1:0];
        head_pc_d = head_pc_q + (compact ? XLEN'(2) : XLEN'(4));
      end
      count_d = count_q + (push ? push_n : CW'(0)) - (pop ? pop_n : CW'(0));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      fetch_pc_q <= RESET_PC & PC_MASK;
      head_pc_q  <= RESET_PC & PC_MASK;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
      head_pc_q  <= head_pc_d;
    end
  end

  // A misaligned fetch PC only wants the upper halfword of the word.
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      if (fetch_pc_q[1]) begin
        mem_q[wr_ptr_q] <= fetch_data[31:16];
      end else begin
        mem_q[wr_ptr_q]          <= fetch_data[15:0];
        mem_q[wr_ptr_q + PW'(1)] <= fetch_data[31:16];
      end
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - directed vector table plus random traffic against a halfword-queue model
module tb_fetch_buffer;

  logic        clock = 1'b0;
  logic        reset, flush, fetch_req, fetch_valid, out_valid, out_ready, out_is_compact;
  logic [31:0] flush_pc, fetch_addr, fetch_data, out_instruction, out_pc;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic        fl;
    logic [31:0] fpc;
    logic        fv;
    logic [31:0] fd;
    logic        rdy;
    logic        v;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] cnt;
    logic        req;
    logic [31:0] addr;
  } vec_t;

  vec_t tbl[$];

  // reference model: queue of halfwords plus two PCs
  logic [15:0] mq[$];
  logic [31:0] m_head, m_fetch;

  always #5 clock = ~clock;

  fetch_buffer #(.DEPTH_HALVES(8), .XLEN(32), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset), .flush(flush), .flush_pc(flush_pc),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_valid(fetch_valid),
    .fetch_data(fetch_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_instruction(out_instruction), .out_pc(out_pc),
    .out_is_compact(out_is_compact), .count(count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic fl, input logic [31:0] fpc, input logic fv,
                     input logic [31:0] fd, input logic rdy, input logic v, input logic [31:0] instr,
                     input logic [31:0] pc, input logic [31:0] cnt, input logic req,
                     input logic [31:0] addr);
    vec_t r;
    r.rst = rst; r.fl = fl; r.fpc = fpc; r.fv = fv; r.fd = fd; r.rdy = rdy;
    r.v = v; r.instr = instr; r.pc = pc; r.cnt = cnt; r.req = req; r.addr = addr;
    tbl.push_back(r);
  endtask

  function automatic logic [15:0] rand_half();
    logic [15:0] h;
    h = 16'($urandom);
    if ($urandom_range(0, 1) == 1) h[1:0] = 2'b11;
    else if (h[1:0] == 2'b11) h[1:0] = 2'b01;
    return h;
  endfunction

  task automatic step(input vec_t v, input bit use_tbl, input string tag);
    int          sz;
    logic [15:0] h0;
    logic        e_comp, e_v, e_req;
    logic [31:0] e_instr;
    reset = v.rst; flush = v.fl; flush_pc = v.fpc;
    fetch_valid = v.fv; fetch_data = v.fd; out_ready = v.rdy;
    #1;
    sz      = mq.size();
    h0      = (sz > 0) ? mq[0] : 16'h0;
    e_comp  = (h0[1:0] != 2'b11);
    e_v     = (sz >= 1 && e_comp) || (sz >= 2);
    e_instr = e_comp ? {16'h0, h0} : ((sz >= 2) ? {mq[1], h0} : 32'h0);
    e_req   = !v.fl && (8 - sz >= 2);
    chk({tag, " model req"},   {31'h0, fetch_req}, {31'h0, e_req});
    chk({tag, " model addr"},  fetch_addr, {m_fetch[31:2], 2'b00});
    chk({tag, " model valid"}, {31'h0, out_valid}, {31'h0, e_v});
    chk({tag, " model pc"},    out_pc, m_head);
    chk({tag, " model count"}, {28'h0, count}, 32'(sz));
    if (e_v) begin
      chk({tag, " model instr"},   out_instruction, e_instr);
      chk({tag, " model compact"}, {31'h0, out_is_compact}, {31'h0, e_comp});
    end
    if (use_tbl) begin
      chk({tag, " valid"}, {31'h0, out_valid}, {31'h0, v.v});
      chk({tag, " pc"},    out_pc, v.pc);
      chk({tag, " count"}, {28'h0, count}, v.cnt);
      chk({tag, " req"},   {31'h0, fetch_req}, {31'h0, v.req});
      chk({tag, " addr"},  fetch_addr, v.addr);
      if (v.v) chk({tag, " instr"}, out_instruction, v.instr);
    end
    @(posedge clock);
    if (v.rst) begin
      mq.delete(); m_head = 32'h0; m_fetch = 32'h0;
    end else if (v.fl) begin
      mq.delete(); m_head = v.fpc & ~32'h1; m_fetch = v.fpc & ~32'h1;
    end else begin
      if (e_v && v.rdy) begin
        void'(mq.pop_front());
        if (!e_comp) void'(mq.pop_front());
        m_head = m_head + (e_comp ? 32'd2 : 32'd4);
      end
      if (e_req && v.fv) begin
        if (m_fetch[1]) begin
          mq.push_back(v.fd[31:16]); m_fetch = m_fetch + 32'd2;
        end else begin
          mq.push_back(v.fd[15:0]); mq.push_back(v.fd[31:16]); m_fetch = m_fetch + 32'd4;
        end
      end
    end
    @(negedge clock);
  endtask

  initial begin
    vec_t r;
    reset = 1'b1; flush = 1'b0; flush_pc = '0; fetch_valid = 1'b0; fetch_data = '0; out_ready = 1'b0;
    @(posedge clock); @(negedge clock);
    mq.delete(); m_head = 32'h0; m_fetch = 32'h0;

    //  rst fl fpc        fv fd            rdy  v  instr         pc         cnt req addr
    add(0, 0, 32'h0,   1, 32'h00100093, 1,   0, 32'h0,        32'h0,     0, 1, 32'h0);
    add(0, 0, 32'h0,   0, 32'h0,        1,   1, 32'h00100093, 32'h0,     2, 1, 32'h4);
    add(0, 0, 32'h0,   0, 32'h0,        0,   0, 32'h0,        32'h4,     0, 1, 32'h4);
    add(0, 0, 32'h0,   1, 32'h45014585, 1,   0, 32'h0,        32'h4,     0, 1, 32'h4);
    add(0, 0, 32'h0,   0, 32'h0,        1,   1, 32'h00004585, 32'h4,     2, 1, 32'h8);
    add(0, 0, 32'h0,   0, 32'h0,        1,   1, 32'h00004501, 32'h6,     1, 1, 32'h8);
    add(0, 0, 32'h0,   0, 32'h0,        0,   0, 32'h0,        32'h8,     0, 1, 32'h8);
    add(0, 0, 32'h0,   1, 32'h00934505, 1,   0, 32'h0,        32'h8,     0, 1, 32'h8);
    add(0, 0, 32'h0,   0, 32'h0,        1,   1, 32'h00004505, 32'h8,     2, 1, 32'hc);
    add(0, 0, 32'h0,   0, 32'h0,        1,   0, 32'h0,        32'ha,     1, 1, 32'hc);
    add(0, 0, 32'h0,   0, 32'h0,        1,   0, 32'h0,        32'ha,     1, 1, 32'hc);
    add(0, 0, 32'h0,   1, 32'h00000010, 1,   0, 32'h0,        32'ha,     1, 1, 32'hc);
    add(0, 0, 32'h0,   0, 32'h0,        1,   1, 32'h00100093, 32'ha,     3, 1, 32'h10);
    add(0, 0, 32'h0,   0, 32'h0,        0,   1, 32'h00000000, 32'he,     1, 1, 32'h10);
    add(0, 1, 32'h107, 0, 32'h0,        1,   1, 32'h00000000, 32'he,     1, 0, 32'h10);
    add(0, 0, 32'h0,   1, 32'h4585abcd, 0,   0, 32'h0,        32'h106,   0, 1, 32'h104);
    add(0, 0, 32'h0,   0, 32'h0,        0,   1, 32'h00004585, 32'h106,   1, 1, 32'h108);
    add(0, 1, 32'h200, 0, 32'h0,        0,   1, 32'h00004585, 32'h106,   1, 0, 32'h108);
    add(0, 0, 32'h0,   1, 32'h00100093, 0,   0, 32'h0,        32'h200,   0, 1, 32'h200);
    add(0, 0, 32'h0,   1, 32'h00200113, 0,   1, 32'h00100093, 32'h200,   2, 1, 32'h204);
    add(0, 0, 32'h0,   1, 32'h00300193, 0,   1, 32'h00100093, 32'h200,   4, 1, 32'h208);
    add(0, 0, 32'h0,   1, 32'h00400213, 0,   1, 32'h00100093, 32'h200,   6, 1, 32'h20c);
    add(0, 0, 32'h0,   1, 32'hdeadbeef, 0,   1, 32'h00100093, 32'h200,   8, 0, 32'h210);
    add(0, 0, 32'h0,   1, 32'hdeadbeef, 1,   1, 32'h00100093, 32'h200,   8, 0, 32'h210);
    add(0, 0, 32'h0,   0, 32'h0,        1,   1, 32'h00200113, 32'h204,   6, 1, 32'h210);
    add(0, 1, 32'h300, 1, 32'h12345678, 1,   1, 32'h00300193, 32'h208,   4, 0, 32'h210);
    add(0, 0, 32'h0,   0, 32'h0,        0,   0, 32'h0,        32'h300,   0, 1, 32'h300);
    add(0, 0, 32'h0,   1, 32'h00100093, 0,   0, 32'h0,        32'h300,   0, 1, 32'h300);
    add(1, 1, 32'h400, 1, 32'h0,        1,   1, 32'h00100093, 32'h300,   2, 0, 32'h304);
    add(0, 0, 32'h0,   0, 32'h0,        0,   0, 32'h0,        32'h0,     0, 1, 32'h0);

    foreach (tbl[i]) step(tbl[i], 1'b1, $sformatf("vec%0d", i));

    for (int n = 0; n < 3000; n++) begin
      r.rst = ($urandom_range(0, 99) == 0);
      r.fl  = ($urandom_range(0, 15) == 0);
      r.fpc = $urandom;
      r.fv  = ($urandom_range(0, 3) != 0);
      r.fd  = {rand_half(), rand_half()};
      r.rdy = ($urandom_range(0, 2) != 0);
      r.v = 1'b0; r.instr = '0; r.pc = '0; r.cnt = '0; r.req = 1'b0; r.addr = '0;
      step(r, 1'b0, $sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
